// File: rtl/fm_pkg.sv
// Shared types and default constants for the FM core register sequencer.
package fm_pkg;

    localparam int FIFO_DEPTH_DEFAULT = 8;
    localparam int GAP_CYCLES_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_SAMPLE,
        ST_GAP
    } fm_state_t;

    typedef struct packed {
        logic       read;
        logic [5:0] addr;
        logic [7:0] data;
    } fm_cmd_t;

endpackage

// File: rtl/fm_cmd_fifo.sv
// Command FIFO: registered storage, so a pushed entry is visible at the head
// only after the push edge.
module fm_cmd_fifo
    import fm_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  fm_cmd_t    din,
    input  logic       pop,
    output fm_cmd_t    dout,
    output logic       full,
    output logic       empty,
    output logic [4:0] level
);

    localparam int AW = $clog2(DEPTH);

    fm_cmd_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + 5'(do_push) - 5'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (level == 5'(DEPTH));
    assign empty = (level == 5'd0);

endmodule

// File: rtl/fm_reg_sequencer.sv
// Serialises queued register reads/writes onto the FM core bus with
// setup/strobe/hold timing and a programmable idle gap between accesses.
module fm_reg_sequencer
    import fm_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_read,
    input  logic [5:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic [5:0] bus_addr,
    output logic [7:0] bus_dout,
    input  logic [7:0] bus_din,
    output logic       bus_rwn,
    output logic       bus_oe,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic [4:0] fifo_level,
    output logic       busy
);

    localparam bit         HAS_GAP  = (GAP_CYCLES > 0);
    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    fm_state_t  state;
    fm_state_t  state_nxt;
    fm_cmd_t    head;
    fm_cmd_t    cmd_in;
    logic       full;
    logic       empty;
    logic       pop;
    logic       cur_read;
    logic [3:0] gap_cnt;

    assign cmd_in    = '{read: cmd_read, addr: cmd_addr, data: cmd_data};
    assign cmd_ready = !full;

    fm_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid && cmd_ready),
        .din   (cmd_in),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP:  state_nxt = cur_read ? ST_SAMPLE : ST_STROBE;
            ST_STROBE: state_nxt = ST_HOLD;
            ST_HOLD, ST_SAMPLE, ST_GAP: begin
                // End of an access: either wait out the gap or chain the next one.
                if (HAS_GAP && (state != ST_GAP || gap_cnt != 4'd0)) begin
                    state_nxt = ST_GAP;
                end else if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_SETUP;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cur_read <= 1'b0;
            bus_addr <= '0;
            bus_dout <= '0;
            gap_cnt  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            state    <= state_nxt;
            rd_valid <= (state == ST_SAMPLE);
            if (state == ST_SAMPLE) rd_data <= bus_din;
            if (pop) begin
                bus_addr <= head.addr;
                bus_dout <= head.data;
                cur_read <= head.read;
            end
            if (state_nxt == ST_GAP && state != ST_GAP) gap_cnt <= GAP_LAST;
            else if (state == ST_GAP)                  gap_cnt <= gap_cnt - 4'd1;
        end
    end

    // Decoded straight from the state register so reset releases the bus at once.
    assign bus_rwn = (state != ST_STROBE);
    assign bus_oe  = (state == ST_STROBE) || (state == ST_HOLD) ||
                     (state == ST_SETUP && !cur_read);
    assign busy    = !empty || (state != ST_IDLE);

endmodule

// File: tb/tb_fm_reg_sequencer.sv
// Scoreboard bench: stimulus pushes expected accesses, a bus monitor acting as
// the FM core retires them in order; directed windows check cycle timing.
module tb_fm_reg_sequencer;

    typedef struct {
        bit         rd;
        logic [5:0] addr;
        logic [7:0] data;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_read = 1'b0;
    logic [5:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic       cmd_ready;
    logic [5:0] bus_addr;
    logic [7:0] bus_dout;
    logic [7:0] bus_din;
    logic       bus_rwn;
    logic       bus_oe;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [4:0] fifo_level;
    logic       busy;

    logic       c2_valid = 1'b0;
    logic       c2_read = 1'b0;
    logic [5:0] c2_addr = '0;
    logic [7:0] c2_data = '0;
    logic [7:0] c2_din = 8'h00;
    logic       c2_ready;
    logic [5:0] c2_bus_addr;
    logic [7:0] c2_bus_dout;
    logic       c2_rwn;
    logic       c2_oe;
    logic       c2_rd_valid;
    logic [7:0] c2_rd_data;
    logic [4:0] c2_level;
    logic       c2_busy;

    logic [7:0] dev_regs   [64];
    logic [7:0] model_regs [64];
    sb_t        exp_q [$];
    int         strobe_log [$];
    int         s2_log [$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         n_strobe = 0;
    bit         saw_full = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus_din = dev_regs[bus_addr];

    fm_reg_sequencer #(.FIFO_DEPTH(8), .GAP_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_read(cmd_read), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_din(bus_din),
        .bus_rwn(bus_rwn), .bus_oe(bus_oe), .rd_valid(rd_valid), .rd_data(rd_data),
        .fifo_level(fifo_level), .busy(busy)
    );

    fm_reg_sequencer #(.FIFO_DEPTH(4), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
        .cmd_read(c2_read), .cmd_addr(c2_addr), .cmd_data(c2_data),
        .bus_addr(c2_bus_addr), .bus_dout(c2_bus_dout), .bus_din(c2_din),
        .bus_rwn(c2_rwn), .bus_oe(c2_oe), .rd_valid(c2_rd_valid), .rd_data(c2_rd_data),
        .fifo_level(c2_level), .busy(c2_busy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    task automatic sb_push(input bit rd, input logic [5:0] a, input logic [7:0] d);
        sb_t e;
        e.rd   = rd;
        e.addr = a;
        if (rd) e.data = model_regs[a];
        else begin
            e.data = d;
            model_regs[a] = d;
        end
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input bit rd, input logic [5:0] a, input logic [7:0] d);
        int g = 0;
        cmd_valid = 1'b1;
        cmd_read  = rd;
        cmd_addr  = a;
        cmd_data  = d;
        while (!cmd_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got ready %0b exp 1", cmd_ready);
        end else begin
            sb_push(rd, a, d);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int g = 0;
        while ((busy || exp_q.size() != 0) && g < 500) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (g >= 500) begin
            errors++;
            $display("FAIL %s drain got pending %0d exp 0", name, exp_q.size());
        end
    endtask

    // FM core model plus in-order scoreboard retirement.
    initial begin
        for (int i = 0; i < 64; i++) dev_regs[i] = 8'(i) ^ 8'hFC;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (!bus_rwn) begin
                    strobe_log.push_back(cyc);
                    n_strobe++;
                    if (exp_q.size() == 0 || exp_q[0].rd) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_strobe got addr %0h exp none", bus_addr);
                    end else begin
                        check("strobe_addr", 32'(bus_addr), 32'(exp_q[0].addr));
                        check("strobe_data", 32'(bus_dout), 32'(exp_q[0].data));
                        check("strobe_oe", 32'(bus_oe), 32'd1);
                        void'(exp_q.pop_front());
                    end
                    dev_regs[bus_addr] = bus_dout;
                end
                if (rd_valid) begin
                    if (exp_q.size() == 0 || !exp_q[0].rd) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rd_valid got data %0h exp none", rd_data);
                    end else begin
                        check("rd_data", 32'(rd_data), 32'(exp_q[0].data));
                        void'(exp_q.pop_front());
                    end
                end
                if (fifo_level == 5'd8) begin
                    saw_full = 1'b1;
                    check("ready_at_full", 32'(cmd_ready), 32'd0);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && !c2_rwn) s2_log.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        int n_low, n_oe, n_rv, strobe_at, first_oe, busy_clear, rv_at, snap, g;
        logic [7:0] rv_data;
        for (int i = 0; i < 64; i++) model_regs[i] = 8'(i) ^ 8'hFC;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rwn", 32'(bus_rwn), 32'd1);
        check("rst_oe", 32'(bus_oe), 32'd0);
        check("rst_addr", 32'(bus_addr), 32'd0);
        check("rst_dout", 32'(bus_dout), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);

        // Single write: SETUP at k=1, STROBE at k=2, HOLD at k=3, gap, idle at k=8.
        send(1'b0, 6'h21, 8'h5A);
        n_low = 0; n_oe = 0; strobe_at = -1; first_oe = -1; busy_clear = -1;
        for (int k = 0; k < 12; k++) begin
            if (!bus_rwn) begin n_low++; strobe_at = k; end
            if (bus_oe) begin n_oe++; if (first_oe < 0) first_oe = k; end
            if (!busy && busy_clear < 0) busy_clear = k;
            @(negedge clk);
        end
        check("wr_strobe_cycles", 32'(n_low), 32'd1);
        check("wr_oe_cycles", 32'(n_oe), 32'd3);
        check("wr_strobe_pos", 32'(strobe_at), 32'd2);
        check("wr_oe_first", 32'(first_oe), 32'd1);
        check("wr_busy_clear", 32'(busy_clear), 32'd8);
        check("wr_addr_hold", 32'(bus_addr), 32'h21);
        wait_idle("write");

        // Single read of 0x3F, core returns 0xC3.
        send(1'b1, 6'h3F, 8'h00);
        n_oe = 0; n_rv = 0; rv_at = -1; rv_data = '0;
        for (int k = 0; k < 12; k++) begin
            if (bus_oe) n_oe++;
            if (rd_valid) begin n_rv++; rv_at = k; rv_data = rd_data; end
            @(negedge clk);
        end
        check("rd_oe_cycles", 32'(n_oe), 32'd0);
        check("rd_pulses", 32'(n_rv), 32'd1);
        check("rd_pulse_pos", 32'(rv_at), 32'd3);
        check("rd_value", 32'(rv_data), 32'hC3);
        check("rd_data_hold", 32'(rd_data), 32'hC3);
        wait_idle("read");

        // Warm-up write keeps one access in flight so the next nine fill the FIFO.
        strobe_log.delete();
        saw_full = 1'b0;
        send(1'b0, 6'h00, 8'h11);
        for (int i = 0; i < 9; i++) send(1'b0, 6'(i + 1), 8'($urandom));
        wait_idle("burst");
        check("burst_count", 32'(strobe_log.size()), 32'd10);
        for (int i = 1; i < strobe_log.size(); i++)
            check("burst_spacing", 32'(strobe_log[i] - strobe_log[i-1]), 32'd7);
        check("burst_saw_full", 32'(saw_full), 32'd1);

        // Zero-gap instance: two writes strobe three cycles apart.
        s2_log.delete();
        c2_valid = 1'b1; c2_addr = 6'h05; c2_data = 8'hA1;
        @(negedge clk);
        c2_addr = 6'h06; c2_data = 8'hA2;
        @(negedge clk);
        c2_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("gap0_count", 32'(s2_log.size()), 32'd2);
        if (s2_log.size() == 2)
            check("gap0_spacing", 32'(s2_log[1] - s2_log[0]), 32'd3);

        // Reset during a strobe with three entries still queued.
        for (int i = 0; i < 5; i++) send(1'b0, 6'(8 + i), 8'($urandom));
        g = 0;
        while (bus_rwn && g < 50) begin @(negedge clk); g++; end
        check("abort_found_strobe", 32'(bus_rwn), 32'd0);
        check("abort_queued", 32'(fifo_level), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_rwn", 32'(bus_rwn), 32'd1);
        check("abort_oe", 32'(bus_oe), 32'd0);
        check("abort_level", 32'(fifo_level), 32'd0);
        check("abort_addr", 32'(bus_addr), 32'd0);
        exp_q.delete();
        snap = n_strobe;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("abort_no_strobes", 32'(n_strobe), 32'(snap));
        check("abort_level_after", 32'(fifo_level), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 64; i++) model_regs[i] = dev_regs[i];

        // Pushes at edges 1..5 from idle; pops at edges 2 and 9, so edge 9 is push+pop at level 4.
        for (int i = 0; i < 5; i++) send(1'b0, 6'(16 + i), 8'($urandom));
        repeat (3) @(negedge clk);
        check("pp_level_before", 32'(fifo_level), 32'd4);
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 6'd16; cmd_data = 8'h00;
        sb_push(1'b1, 6'd16, 8'h00);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("pp_level_after", 32'(fifo_level), 32'd4);
        wait_idle("push_pop");

        // Random mix over a small address window so reads observe earlier writes.
        for (int i = 0; i < 24; i++) begin
            send(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle("random");
        check("final_level", 32'(fifo_level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fm_reg_sequencer.md
FM_REG_SEQUENCER -- requirements
Module: fm_reg_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, command FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter GAP_CYCLES, default 4, idle bus cycles after each access (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_read  input  1  1 = register read, 0 = write.
REQ-008 SHALL have port cmd_addr  input  6  FM core register address.
REQ-009 SHALL have port cmd_data  input  8  write data; ignored for reads.
REQ-010 SHALL have port bus_addr  output  6  FM core address bus.
REQ-011 SHALL have port bus_dout  output  8  data driven to FM core.
REQ-012 SHALL have port bus_din  input  8  data returned by FM core.
REQ-013 SHALL have port bus_rwn  output  1  1 = read/idle, 0 = write strobe.
REQ-014 SHALL have port bus_oe  output  1  enable for external data pad drivers.
REQ-015 SHALL have port rd_valid  output  1  one-cycle read-result pulse.
REQ-016 SHALL have port rd_data  output  8  last read result.
REQ-017 SHALL have port fifo_level  output  5  current FIFO occupancy.
REQ-018 SHALL have port busy  output  1  FIFO non-empty or FSM not IDLE.

Function
REQ-019 SHALL push {read,addr,data} on every edge with cmd_valid and cmd_ready; cmd_ready = (fifo_level != FIFO_DEPTH).
REQ-020 SHALL have no fall-through: an entry pushed at edge N is popped no earlier than edge N+1.
REQ-021 SHALL use FSM states IDLE, SETUP, STROBE, HOLD, SAMPLE, GAP.
REQ-022 IDLE: FIFO non-empty -> pop, latch entry onto bus_addr/bus_dout, go SETUP.
REQ-023 SETUP (1 cycle): bus_rwn=1, bus_oe = ~read; next STROBE for writes, SAMPLE for reads.
REQ-024 STROBE (1 cycle): bus_rwn=0, bus_oe=1; next HOLD.
REQ-025 HOLD (1 cycle): bus_rwn=1, bus_oe=1, address/data unchanged; next GAP.
REQ-026 SAMPLE (1 cycle): bus_rwn=1, bus_oe=0; bus_din captured into rd_data at end of cycle; rd_valid high the following cycle for exactly one cycle; next GAP.
REQ-027 GAP: GAP_CYCLES cycles, bus_rwn=1, bus_oe=0; at end, FIFO non-empty -> pop and go SETUP directly, else IDLE; GAP_CYCLES=0 skips GAP entirely.
REQ-028 Back-to-back write period SHALL be exactly 3+GAP_CYCLES cycles; read period likewise 2+GAP_CYCLES.
REQ-029 Push and pop on the same edge SHALL leave fifo_level unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-030 bus_addr/bus_dout SHALL hold their last values outside accesses; rd_data holds until next SAMPLE.
REQ-031 bus_oe SHALL never be high while the FSM is in SAMPLE, GAP or IDLE.

Reset
REQ-032 Reset SHALL force: state IDLE, FIFO empty, fifo_level=0, cmd_ready=1 after release, busy=0, bus_rwn=1, bus_oe=0, bus_addr=0, bus_dout=0, rd_valid=0, rd_data=0.
REQ-033 Reset asserted mid-access SHALL abandon it immediately (bus_rwn=1 asynchronously); flushed entries are never issued.

Structure
REQ-034 State encoding enum and default parameter constants SHALL live in shared package fm_pkg.
REQ-035 FIFO SHALL be a sub-module fm_cmd_fifo (push/pop, full, empty, level); FSM and bus drive in fm_reg_sequencer.

Verification
REQ-036 Single write addr=0x21 data=0x5A, GAP=4 -> SETUP/STROBE/HOLD, bus_rwn low exactly 1 cycle, bus_oe high 3 cycles, busy clears 7 cycles after pop.
REQ-037 Read addr=0x3F with bus_din=0xC3 -> bus_oe never high, rd_valid single pulse with rd_data=0xC3.
REQ-038 Push 9 writes back-to-back, depth 8 -> cmd_ready low when level 8, all 9 issued in order at 7-cycle spacing.
REQ-039 GAP_CYCLES=0, two writes -> strobes exactly 3 cycles apart.
REQ-040 rst_n low during STROBE with 3 entries queued -> bus_rwn=1, bus_oe=0 immediately, no further strobes after release, fifo_level=0.
REQ-041 Simultaneous push/pop at level 4 -> level stays 4; pointer wrap after 20 commands preserves order.
